host_cmd_master: RTL
====================

Name: host_cmd_master

Overview:
- Host-side counterpart of the accelerator's instruction buffer and output buffer.
- Queues 64-bit instructions from a host-side valid/ready port and issues them to the accelerator's 64-bit instruction input, stalling while the accelerator reports its buffer full.
- For read-out instructions, waits a fixed latency, samples the accelerator's 32-bit result bus and returns it to the host with its output-buffer address.
- Sits in the testbench/host wrapper, outside the accelerator, on the same clock as the accelerator core.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
- RD_OPCODE, 4'hF, value of instr[63:60] that marks an output-buffer read instruction
- RD_LATENCY, 2, cycles from issue of a read until the result on acc_result is valid (>=1)

Ports:
- clk  input  1  core clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  host presents cmd_instr
- cmd_instr  input  64  instruction to queue
- cmd_ready  output  1  FIFO can accept; transfer on cmd_valid&&cmd_ready
- acc_instr  output  64  instruction to accelerator input
- acc_instr_valid  output  1  one-cycle pulse, acc_instr is a new instruction
- acc_buffer_full  input  1  accelerator instruction buffer full; no issue while high
- acc_result  input  32  accelerator result bus
- rsp_valid  output  1  one-cycle pulse, rsp_data/rsp_addr valid
- rsp_data  output  32  captured result
- rsp_addr  output  4  instr[3:0] of the read that produced rsp_data
- busy  output  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and count = 0; FSM = IDLE.
  - acc_instr = 0, acc_instr_valid = 0, rsp_valid = 0, rsp_data = 0, rsp_addr = 0, busy = 0.
  - cmd_ready = 1 once reset deasserts.
  - Reset mid-read drops the pending read; no rsp_valid is produced.
- FIFO:
  - cmd_ready = (count < CMD_DEPTH), combinational from count.
  - Push on cmd_valid&&cmd_ready; pop only in IDLE when issuing.
  - Simultaneous push and pop when full is not possible (cmd_ready=0).
  - Simultaneous push and pop when non-full: count unchanged, both pointers advance.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states IDLE, ISSUE, WAIT_RD, RESP:
  - IDLE:
    - If count>0 and !acc_buffer_full: register head into acc_instr, pop, go ISSUE.
    - If acc_buffer_full=1: hold, no pop, no pulse.
  - ISSUE: acc_instr_valid=1 for exactly this cycle.
    - If acc_instr[63:60]==RD_OPCODE: latch rsp_addr from acc_instr[3:0], load wait counter = RD_LATENCY-1, go WAIT_RD.
    - Otherwise: go IDLE.
  - WAIT_RD:
    - Decrement counter each cycle; at 0, capture acc_result into rsp_data and go RESP.
    - No new instruction is issued while in WAIT_RD.
  - RESP: rsp_valid=1 for one cycle; go IDLE.
- acc_instr holds its last value when acc_instr_valid=0.
- Latency:
  - Empty FIFO push at cycle t → acc_instr_valid at t+2 (push t, IDLE pop t+1, ISSUE t+2).
  - Non-read back-to-back issue rate: one per 2 cycles.
  - Read turnaround: ISSUE at cycle i, acc_result sampled on the edge ending cycle i+RD_LATENCY, rsp_valid at i+RD_LATENCY+1.
- acc_buffer_full sampled only in IDLE; changes during ISSUE/WAIT_RD/RESP are ignored.
- busy = (count!=0) || (state!=IDLE).

Test Plan:
- Reset release, no commands → cmd_ready=1, acc_instr_valid=0, rsp_valid=0, busy=0 for 20 cycles.
- Push 64'h1000_0000_0000_00AB with acc_buffer_full=0 → acc_instr=64'h1000_0000_0000_00AB with one-cycle acc_instr_valid 2 cycles after push; no rsp_valid; busy drops after.
- Push read 64'hF000_0000_0000_0007; accelerator model drives acc_result=32'hDEAD_BEEF exactly RD_LATENCY cycles after the issue pulse → rsp_valid one cycle with rsp_data=32'hDEAD_BEEF, rsp_addr=4'h7.
- acc_buffer_full=1, push 5 commands → first 4 accepted, cmd_ready=0 on 5th, no acc_instr_valid; release full → 4 issues in FIFO order, 2 cycles apart; 5th then accepted.
- Pointer wrap: push/issue 10 mixed commands, 3 of them reads at addresses 1,2,3 → issue order matches push order; 3 rsp_valid pulses with rsp_addr 1,2,3 in order.
- Assert reset during WAIT_RD → all outputs 0 immediately, no rsp_valid after release, FIFO empty (cmd_ready=1).

Source files
------------

// File: rtl/host_cmd_master_if.sv
// ---------------------------------------------------------------------------
// host_cmd_master_if
//   Groups the host command port, the accelerator instruction/result port,
//   the host response port and status/debug signals of host_cmd_master.
//
//   Handshake rules (valid/ready semantics):
//     - cmd: a transfer happens on a rising edge where cmd_valid && cmd_ready.
//       The host holds cmd_instr stable while cmd_valid is high and not yet
//       accepted. cmd_ready does not depend on cmd_valid.
//     - acc_instr_valid / rsp_valid are one-cycle pulses with no back-pressure;
//       the receiver must take acc_instr / rsp_data+rsp_addr in that cycle.
//     - acc_buffer_full is a level; no instruction is issued while it is high.
//
//   Modports:
//     master : the host_cmd_master block itself
//     slave  : the host / accelerator side (testbench or wrapper)
// ---------------------------------------------------------------------------
interface host_cmd_master_if;
  logic        cmd_valid;
  logic [63:0] cmd_instr;
  logic        cmd_ready;

  logic [63:0] acc_instr;
  logic        acc_instr_valid;
  logic        acc_buffer_full;
  logic [31:0] acc_result;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_addr;

  logic        busy;
  logic [1:0]  dbg_state;  // current FSM state, for checkers and debug

  modport master (
    input  cmd_valid, cmd_instr, acc_buffer_full, acc_result,
    output cmd_ready, acc_instr, acc_instr_valid, rsp_valid, rsp_data,
           rsp_addr, busy, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_instr, acc_buffer_full, acc_result,
    input  cmd_ready, acc_instr, acc_instr_valid, rsp_valid, rsp_data,
           rsp_addr, busy, dbg_state
  );
endinterface

// File: rtl/host_cmd_master.sv
// ---------------------------------------------------------------------------
// host_cmd_master
//   Host-side feeder for the accelerator. Buffers 64-bit instructions in a
//   small FIFO, issues them one at a time to the accelerator (holding off
//   while the accelerator buffer is full), and for output-buffer read
//   instructions waits RD_LATENCY cycles, captures acc_result and returns it
//   to the host together with the read address instr[3:0].
//
//   Ports:
//     clk    : core clock, all logic on the rising edge
//     reset  : asynchronous, active-high reset
//     bus    : host_cmd_master_if.master
//              cmd_valid/cmd_instr/cmd_ready   host command port
//              acc_instr/acc_instr_valid       instruction to accelerator
//              acc_buffer_full                 accelerator back-pressure
//              acc_result                      accelerator result bus
//              rsp_valid/rsp_data/rsp_addr     read response to host
//              busy                            FIFO non-empty or FSM active
//              dbg_state                       FSM state
// ---------------------------------------------------------------------------
module host_cmd_master #(
  parameter int         CMD_DEPTH  = 4,
  parameter logic [3:0] RD_OPCODE  = 4'hF,
  parameter int         RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  host_cmd_master_if.master  bus
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  // FIFO
  logic [63:0]      mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // FSM and datapath registers
  state_e           state_q, state_d;
  logic [63:0]      acc_instr_q, acc_instr_d;
  logic [LAT_W-1:0] wait_q, wait_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_addr_q, rsp_addr_d;

  logic             cmd_ready;

  assign cmd_ready = (count_q < CNT_W'(CMD_DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;
  // Pop is the issue decision: only from IDLE, only when the accelerator
  // has room. acc_buffer_full is ignored in every other state.
  assign pop       = (state_q == IDLE) && (count_q != '0) && !bus.acc_buffer_full;

  // ---------------- FIFO ----------------
  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.cmd_instr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d     = state_q;
    acc_instr_d = acc_instr_q;
    wait_d      = wait_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          acc_instr_d = mem_q[rd_ptr_q];
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (acc_instr_q[63:60] == RD_OPCODE) begin
          rsp_addr_d = acc_instr_q[3:0];
          // Counter reaches 0 in the cycle whose closing edge samples
          // acc_result, i.e. RD_LATENCY cycles after the issue cycle.
          wait_d     = LAT_W'(RD_LATENCY - 1);
          state_d    = WAIT_RD;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_RD: begin
        if (wait_q == '0) begin
          rsp_data_d = bus.acc_result;
          state_d    = RESP;
        end else begin
          wait_d = wait_q - LAT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_instr_q <= '0;
      wait_q      <= '0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_instr_q <= acc_instr_d;
      wait_q      <= wait_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // ---------------- Outputs ----------------
  // The pulses are decoded from registered state, so they are glitch-free
  // and drop immediately on asynchronous reset.
  assign bus.cmd_ready       = cmd_ready;
  assign bus.acc_instr       = acc_instr_q;
  assign bus.acc_instr_valid = (state_q == ISSUE);
  assign bus.rsp_valid       = (state_q == RESP);
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_addr        = rsp_addr_q;
  assign bus.busy            = (count_q != '0) || (state_q != IDLE);
  assign bus.dbg_state       = state_q;

endmodule
